iterative_shift_unit: RTL and testbench

//  Multi-cycle shift unit in the EX stage for RV32I SLL/SRL/SRA (and SLLI/SRLI/SRAI).

---
 rtl/riscv_pkg.sv | 17 +
 rtl/iterative_shift_unit_shift_step.sv | 68 ++++++
 rtl/iterative_shift_unit.sv | 102 ++++++++++
 tb/tb_iterative_shift_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the EX-stage shift unit: opcode encodings and FSM states.
package riscv_pkg;

  // Shift operation encodings as presented on the op port.
  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_RSV = 2'b11;

  // Iterative shift unit states.
  typedef enum logic [1:0] {
    IS_IDLE  = 2'b00,
    IS_SHIFT = 2'b01,
    IS_DONE  = 2'b10
  } is_state_t;

endpackage

// File: rtl/iterative_shift_unit_shift_step.sv
// One-position shift step: existing left/right shifters at distance 1 plus an
// MSB-fill mux that turns the logical right shift into an arithmetic one.

// Fixed-distance logical left shifter.
module shift_left #(
  parameter int N = 32,
  parameter int L = 1
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);
  assign y = x << L;
endmodule

// Fixed-distance logical right shifter.
module shift_right #(
  parameter int N = 32,
  parameter int R = 1
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);
  assign y = x >> R;
endmodule

module shift_step
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] w,
  input  logic [1:0]   op,
  output logic [N-1:0] y
);

  logic [N-1:0] shl_y;
  logic [N-1:0] shr_y;
  logic [N-1:0] sra_y;

  shift_left #(.N(N), .L(1)) u_shl (
    .x (w),
    .y (shl_y)
  );

  shift_right #(.N(N), .R(1)) u_shr (
    .x (w),
    .y (shr_y)
  );

  // Arithmetic right: logical result with the vacated MSB refilled from the sign.
  always_comb begin
    sra_y        = shr_y;
    sra_y[N-1]   = w[N-1];
  end

  // Select the step for the latched operation; reserved op leaves the word as is.
  always_comb begin
    y = w;
    unique case (op)
      SHIFT_OP_SLL: y = shl_y;
      SHIFT_OP_SRL: y = shr_y;
      SHIFT_OP_SRA: y = sra_y;
      SHIFT_OP_RSV: y = w;
      default:      y = w;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle RV32I shift unit: shifts one bit position per clock, holding the
// pipeline via busy, and pulses done with a registered result.
module iterative_shift_unit
  import riscv_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result
);

  is_state_t          state_q;
  is_state_t          state_d;
  logic [N-1:0]       work_q;
  logic [N-1:0]       result_q;
  logic [N-1:0]       step_y;
  logic [SHAMT_W-1:0] cnt_q;
  logic [1:0]         op_q;
  logic               accept;

  shift_step #(.N(N)) u_step (
    .w  (work_q),
    .op (op_q),
    .y  (step_y)
  );

  // Next-state logic; flush overrides everything, including a new start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IS_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (shamt != '0) ? IS_SHIFT : IS_DONE;
        end
      end
      IS_SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) state_d = IS_DONE;
      end
      IS_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (shamt != '0) ? IS_SHIFT : IS_DONE;
        end else begin
          state_d = IS_IDLE;
        end
      end
      default: state_d = IS_IDLE;
    endcase
    if (flush) begin
      state_d = IS_IDLE;
      accept  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IS_IDLE;
    else     state_q <= state_d;
  end

  // Working word, remaining count and latched op: load on accept, step in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= SHIFT_OP_SLL;
    end else if (accept) begin
      work_q <= a;
      cnt_q  <= shamt;
      op_q   <= op;
    end else if (state_q == IS_SHIFT && !flush) begin
      work_q <= step_y;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

  // Result is captured on the edge entering DONE so it is valid alongside done:
  // a zero-shift job takes the operand directly, otherwise the final step output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_d == IS_DONE) begin
      result_q <= accept ? a : step_y;
    end
  end

  assign busy   = (state_q == IS_SHIFT);
  assign done   = (state_q == IS_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed testbench for iterative_shift_unit.
module tb_iterative_shift_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  iterative_shift_unit #(.N(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a job during the current (low) clock phase; start drops after the edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
    start = 1'b1;
    op    = o;
    a     = x;
    shamt = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles after the start edge until done, bounded; returns at the DONE negedge.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (done) break;
    end
  endtask

  task automatic job(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [4:0] s, input logic [31:0] exp);
    int cyc, nb;
    @(negedge clk);
    launch(o, x, s);
    wait_done(cyc, nb);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(s) + 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(s));
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nb, pulses;

    // Reset values while reset is held.
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Case 1: SLL 1 by 4.
    job("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
    @(negedge clk);
    check("sll4_done_pulse_len", {31'd0, done}, 32'd0);
    check("sll4_result_held", result, 32'h0000_0010);

    // Case 2: max shift, arithmetic and logical.
    job("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    job("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    job("sra_pos", 2'b10, 32'h4000_0000, 5'd2, 32'h1000_0000);

    // Case 3: zero shift amount.
    job("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);

    // Reserved op passes the operand through after counting.
    job("rsv3", 2'b11, 32'h1234_5678, 5'd3, 32'h1234_5678);

    // Case 4: back-to-back, second start in the DONE cycle.
    @(negedge clk);
    launch(2'b00, 32'd3, 5'd2);
    wait_done(cyc, nb);
    check("b2b1_done_cycle", 32'(cyc), 32'd3);
    check("b2b1_result", result, 32'd12);
    launch(2'b01, 32'd8, 5'd3);
    @(negedge clk);
    check("b2b2_no_bubble", {31'd0, busy}, 32'd1);
    wait_done(cyc, nb);
    check("b2b2_done_cycle", 32'(cyc), 32'd3);
    check("b2b2_busy_cycles", 32'(nb), 32'd2);
    check("b2b2_result", result, 32'd1);

    // Case 5: flush in the second SHIFT cycle with prior result 5.
    job("prior5", 2'b00, 32'd5, 5'd0, 32'd5);
    @(negedge clk);
    launch(2'b00, 32'd1, 5'd8);
    @(negedge clk);
    check("flush_shift1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    a     = 32'hFFFF_0000;
    shamt = 5'd0;
    @(posedge clk);
    #1 flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("flush_no_activity", 32'(pulses), 32'd0);
    check("flush_result_kept", result, 32'd5);

    // Case 6: asynchronous reset mid-SHIFT.
    @(negedge clk);
    launch(2'b00, 32'd1, 5'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("arst_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    job("post_rst_sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
